float_min_search_ctrl: RTL and testbench

- Sequences one shared single-precision float_cmp instance (AXI-stream compare, "less-than" configuration) to find the minimum value and its index over a stream of up to 2^LEN_W-1 floats.
- Sits between a float producer (valid/ready stream) and downstream logic that consumes a single {min_val, min_idx} result per search.
- Issues one compare at a time, because the running minimum depends on the previous compare result.

---
 rtl/float_min_search_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_float_min_search_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_min_search_ctrl.sv
// Minimum-value/index search over a float stream, driving one shared float_cmp (a < b).
// Optional NaN skipping is enabled by defining FLOAT_MIN_SEARCH_NAN_SKIP_EN.
module float_min_search_ctrl #(
    parameter int LEN_W       = 16,
    parameter int CMP_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    output logic             s_ready,
    output logic             cmp_a_valid,
    output logic [31:0]      cmp_a_data,
    output logic             cmp_b_valid,
    output logic [31:0]      cmp_b_data,
    input  logic             cmp_res_valid,
    input  logic [7:0]       cmp_res_data,
    output logic             busy,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      min_val,
    output logic [LEN_W-1:0] min_idx,
    output logic             empty
);

    localparam int GW = (CMP_LATENCY > 0) ? $clog2(CMP_LATENCY + 1) : 1;
    localparam logic [GW-1:0]    GUARD_INIT = GW'(CMP_LATENCY);
    localparam logic [GW-1:0]    GUARD_ONE  = GW'(1);
    localparam logic [GW-1:0]    GUARD_ZERO = GW'(0);
    localparam logic [31:0]      POS_INF    = 32'h7F80_0000;
    localparam logic [LEN_W-1:0] IDX_ZERO   = LEN_W'(0);
    localparam logic [LEN_W-1:0] IDX_ONE    = LEN_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRST  = 3'd1,
        ST_FETCH  = 3'd2,
        ST_CMP    = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RESULT = 3'd5
    } state_e;

    state_e           state_q;
    logic [GW-1:0]    guard_q;
    logic [GW-1:0]    guard_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_inc_d;
    logic             last_d;
    logic [31:0]      cand_q;
    logic [LEN_W-1:0] cand_idx_q;
    logic [31:0]      min_val_q;
    logic [LEN_W-1:0] min_idx_q;
    logic             s_ready_q;
    logic             cmp_valid_q;
    logic             m_valid_q;
    logic             empty_q;
    logic             res_unused_s;

`ifdef FLOAT_MIN_SEARCH_NAN_SKIP_EN
    logic nomin_q;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction
`endif

    // Guard countdown and element-counter arithmetic shared by several states.
    always_comb begin
        guard_d   = guard_q;
        cnt_inc_d = cnt_q + IDX_ONE;
        last_d    = (cnt_inc_d == len_q);
        if (guard_q != GUARD_ZERO) begin
            guard_d = guard_q - GUARD_ONE;
        end else begin
            guard_d = GUARD_ZERO;
        end
    end

    // Search sequencer; all outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            guard_q     <= GUARD_INIT;
            len_q       <= IDX_ZERO;
            cnt_q       <= IDX_ZERO;
            cand_q      <= 32'h0000_0000;
            cand_idx_q  <= IDX_ZERO;
            min_val_q   <= POS_INF;
            min_idx_q   <= IDX_ZERO;
            s_ready_q   <= 1'b0;
            cmp_valid_q <= 1'b0;
            m_valid_q   <= 1'b0;
            empty_q     <= 1'b0;
`ifdef FLOAT_MIN_SEARCH_NAN_SKIP_EN
            nomin_q     <= 1'b0;
`endif
        end else begin
            guard_q     <= guard_d;
            cmp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && (guard_q == GUARD_ZERO)) begin
                        len_q <= len;
                        if (len == IDX_ZERO) begin
                            state_q   <= ST_RESULT;
                            m_valid_q <= 1'b1;
                            empty_q   <= 1'b1;
                            min_val_q <= POS_INF;
                            min_idx_q <= IDX_ZERO;
                        end else begin
                            state_q   <= ST_FIRST;
                            s_ready_q <= 1'b1;
                            empty_q   <= 1'b0;
                        end
                    end
                end
                ST_FIRST: begin
                    if (s_valid) begin
                        min_idx_q <= IDX_ZERO;
                        cnt_q     <= IDX_ONE;
`ifdef FLOAT_MIN_SEARCH_NAN_SKIP_EN
                        if (is_nan(s_data)) begin
                            min_val_q <= POS_INF;
                            nomin_q   <= 1'b1;
                        end else begin
                            min_val_q <= s_data;
                            nomin_q   <= 1'b0;
                        end
`else
                        min_val_q <= s_data;
`endif
                        if (len_q == IDX_ONE) begin
                            state_q   <= ST_RESULT;
                            s_ready_q <= 1'b0;
                            m_valid_q <= 1'b1;
                        end else begin
                            state_q   <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (s_valid) begin
`ifdef FLOAT_MIN_SEARCH_NAN_SKIP_EN
                        // NaNs and the first real value after leading NaNs bypass the comparator.
                        if (is_nan(s_data) || nomin_q) begin
                            if (!is_nan(s_data)) begin
                                min_val_q <= s_data;
                                min_idx_q <= cnt_q;
                                nomin_q   <= 1'b0;
                            end
                            cnt_q <= cnt_inc_d;
                            if (last_d) begin
                                state_q   <= ST_RESULT;
                                s_ready_q <= 1'b0;
                                m_valid_q <= 1'b1;
                            end else begin
                                state_q   <= ST_FETCH;
                            end
                        end else begin
                            cand_q      <= s_data;
                            cand_idx_q  <= cnt_q;
                            state_q     <= ST_CMP;
                            s_ready_q   <= 1'b0;
                            cmp_valid_q <= 1'b1;
                        end
`else
                        cand_q      <= s_data;
                        cand_idx_q  <= cnt_q;
                        state_q     <= ST_CMP;
                        s_ready_q   <= 1'b0;
                        cmp_valid_q <= 1'b1;
`endif
                    end
                end
                ST_CMP: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cmp_res_valid) begin
                        if (cmp_res_data[0]) begin
                            min_val_q <= cand_q;
                            min_idx_q <= cand_idx_q;
                        end
                        cnt_q <= cnt_inc_d;
                        if (last_d) begin
                            state_q   <= ST_RESULT;
                            m_valid_q <= 1'b1;
                        end else begin
                            state_q   <= ST_FETCH;
                            s_ready_q <= 1'b1;
                        end
                    end
                end
                ST_RESULT: begin
                    if (m_ready) begin
                        state_q   <= ST_IDLE;
                        m_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    s_ready_q <= 1'b0;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign res_unused_s = ^cmp_res_data[7:1];

    assign s_ready     = s_ready_q;
    assign cmp_a_valid = cmp_valid_q;
    assign cmp_b_valid = cmp_valid_q;
    assign cmp_a_data  = cand_q;
    assign cmp_b_data  = min_val_q;
    assign busy        = (state_q != ST_IDLE) || (guard_q != GUARD_ZERO);
    assign m_valid     = m_valid_q;
    assign min_val     = min_val_q;
    assign min_idx     = min_idx_q;
    assign empty       = empty_q;

endmodule

// File: tb/tb_float_min_search_ctrl.sv
// Randomized and directed bench for float_min_search_ctrl with a 2-cycle float_cmp model.
module tb_float_min_search_ctrl;

    localparam int LEN_W = 16;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             s_valid;
    logic [31:0]      s_data;
    logic             s_ready;
    logic             cmp_a_valid;
    logic [31:0]      cmp_a_data;
    logic             cmp_b_valid;
    logic [31:0]      cmp_b_data;
    logic             cmp_res_valid;
    logic [7:0]       cmp_res_data;
    logic             busy;
    logic             m_valid;
    logic             m_ready;
    logic [31:0]      min_val;
    logic [LEN_W-1:0] min_idx;
    logic             empty;

    float_min_search_ctrl #(.LEN_W(LEN_W), .CMP_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .cmp_a_valid(cmp_a_valid), .cmp_a_data(cmp_a_data),
        .cmp_b_valid(cmp_b_valid), .cmp_b_data(cmp_b_data),
        .cmp_res_valid(cmp_res_valid), .cmp_res_data(cmp_res_data),
        .busy(busy), .m_valid(m_valid), .m_ready(m_ready),
        .min_val(min_val), .min_idx(min_idx), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          acc_cnt = 0;
    int          cmp_cnt = 0;
    logic        pv0 = 1'b0, pv1 = 1'b0, pr0 = 1'b0, pr1 = 1'b0;
    logic        stale_v = 1'b0;
    logic [31:0] elems [0:15];

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // IEEE less-than: unordered is false, signed zeros compare equal.
    function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ka, kb;
        if (is_nan(a) || is_nan(b)) return 1'b0;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b0;
        ka = a[31] ? ~a : (a | 32'h8000_0000);
        kb = b[31] ? ~b : (b | 32'h8000_0000);
        return ka < kb;
    endfunction

    // float_cmp stand-in plus handshake counters.
    always @(posedge clk) begin
        pv0 <= cmp_a_valid && cmp_b_valid;
        pr0 <= f_lt(cmp_a_data, cmp_b_data);
        pv1 <= pv0;
        pr1 <= pr0;
        if (cmp_a_valid) cmp_cnt <= cmp_cnt + 1;
        if (s_valid && s_ready) acc_cnt <= acc_cnt + 1;
    end
    assign cmp_res_valid = pv1 | stale_v;
    assign cmp_res_data  = stale_v ? 8'h01 : {7'd0, pr1};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sequential scan of the element list: what the search should report.
    task automatic ref_min(input int n, output logic [31:0] val, output logic [LEN_W-1:0] idx,
                           output int cmps);
        bit have = 1'b0;
        val  = POS_INF;
        idx  = '0;
        cmps = 0;
        for (int i = 0; i < n; i++) begin
`ifdef FLOAT_MIN_SEARCH_NAN_SKIP_EN
            if (is_nan(elems[i])) continue;
`endif
            if (!have) begin
                val  = elems[i];
                idx  = LEN_W'(i);
                have = 1'b1;
            end else begin
                cmps++;
                if (f_lt(elems[i], val)) begin
                    val = elems[i];
                    idx = LEN_W'(i);
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_float();
        int r = int'($urandom_range(0, 15));
        case (r)
            0:       return 32'h7FC0_0000;
            1:       return 32'h0000_0000;
            2:       return 32'h8000_0000;
            3:       return 32'hFF80_0000;
            default: return {1'($urandom_range(0, 1)), 8'(125 + $urandom_range(0, 4)),
                             3'($urandom_range(0, 3)), 20'd0};
        endcase
    endfunction

    task automatic do_search(input string tag, input int n, input int gap, input int mhold);
        logic [31:0]      exp_val;
        logic [LEN_W-1:0] exp_idx;
        int exp_cmps, cyc, gap_cnt, seen, acc_base, cmp_base;
        ref_min(n, exp_val, exp_idx, exp_cmps);
        cyc = 0;
        while (busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_idle"}, 64'(busy), 64'd0);
        acc_base = acc_cnt;
        cmp_base = cmp_cnt;
        start = 1'b1;
        len   = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        len   = LEN_W'($urandom);
        if (n == 0) begin
            check_eq({tag, "_mv_next"}, 64'(m_valid), 64'd1);
            check_eq({tag, "_no_sready"}, 64'(s_ready), 64'd0);
        end else begin
            check_eq({tag, "_sready"}, 64'(s_ready), 64'd1);
        end
        gap_cnt = 0;
        seen    = acc_cnt;
        cyc     = 0;
        while (!m_valid && cyc < 3000) begin
            if (acc_cnt != seen) begin
                seen    = acc_cnt;
                gap_cnt = gap;
            end
            if ((acc_cnt - acc_base) < n && gap_cnt == 0) begin
                s_valid = 1'b1;
                s_data  = elems[acc_cnt - acc_base];
            end else begin
                s_valid = 1'b0;
                s_data  = $urandom;
                if (gap_cnt > 0) gap_cnt--;
            end
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        check_eq({tag, "_done"}, 64'(m_valid), 64'd1);
        check_eq({tag, "_val"}, 64'(min_val), 64'(exp_val));
        check_eq({tag, "_idx"}, 64'(min_idx), 64'(exp_idx));
        check_eq({tag, "_empty"}, 64'(empty), 64'(n == 0));
        check_eq({tag, "_accepted"}, 64'(acc_cnt - acc_base), 64'(n));
        check_eq({tag, "_cmps"}, 64'(cmp_cnt - cmp_base), 64'(exp_cmps));
        for (int k = 0; k < mhold; k++) begin
            @(negedge clk);
            check_eq({tag, "_hold_mv"}, 64'(m_valid), 64'd1);
            check_eq({tag, "_hold_val"}, 64'({min_val, min_idx, empty}),
                     64'({exp_val, exp_idx, n == 0}));
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check_eq({tag, "_mv_drop"}, 64'(m_valid), 64'd0);
    endtask

    initial begin
        int cyc;
        rst_n   = 1'b0;
        start   = 1'b0;
        len     = '0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd1);
        check_eq("rst_outs", 64'({s_ready, cmp_a_valid, cmp_b_valid, m_valid, empty}), 64'd0);
        check_eq("rst_min", 64'({min_val, min_idx}), 64'({POS_INF, 16'd0}));
        rst_n = 1'b1;

        elems[0] = 32'h4040_0000; elems[1] = 32'h3F80_0000;
        elems[2] = 32'h4000_0000; elems[3] = 32'hC0A0_0000;
        do_search("flow", 4, 0, 0);

        elems[0] = 32'h4000_0000; elems[1] = 32'h3F80_0000; elems[2] = 32'h3F80_0000;
        do_search("ties", 3, 0, 0);

        elems[0] = 32'h0000_0000; elems[1] = 32'h8000_0000;
        do_search("zeros", 2, 0, 0);

        do_search("len0", 0, 0, 2);

        elems[0] = 32'h40A0_0000; elems[1] = 32'h4080_0000;
        do_search("bp", 2, 3, 5);

        elems[0] = 32'h7FC0_0000; elems[1] = 32'h4000_0000; elems[2] = 32'h3F80_0000;
        do_search("nan", 3, 0, 0);

        elems[0] = 32'h7FC0_0000; elems[1] = 32'h7FC0_0001;
        do_search("allnan", 2, 0, 0);

        // Reset while a compare is in flight.
        elems[0] = 32'h4040_0000; elems[1] = 32'h3F80_0000;
        elems[2] = 32'h4000_0000; elems[3] = 32'hC0A0_0000;
        start = 1'b1;
        len   = 16'd4;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!cmp_a_valid && cyc < 50) begin
            s_valid = 1'b1;
            s_data  = elems[0];
            @(negedge clk);
            s_data  = elems[1];
            cyc++;
        end
        s_valid = 1'b0;
        check_eq("mid_cmp_seen", 64'(cmp_a_valid), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_outs", 64'({s_ready, cmp_a_valid, m_valid, empty}), 64'd0);
        check_eq("mid_rst_min", 64'({min_val, min_idx}), 64'({POS_INF, 16'd0}));
        check_eq("mid_rst_busy", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        len   = 16'd1;
        #1;
        check_eq("guard_busy0", 64'(busy), 64'd1);
        @(negedge clk);
        start   = 1'b0;
        stale_v = 1'b1;
        check_eq("guard_busy1", 64'(busy), 64'd1);
        check_eq("guard_quiet1", 64'({s_ready, m_valid}), 64'd0);
        @(negedge clk);
        stale_v = 1'b0;
        check_eq("guard_busy2", 64'(busy), 64'd0);
        check_eq("guard_quiet2", 64'({s_ready, m_valid, cmp_a_valid}), 64'd0);
        check_eq("guard_min", 64'({min_val, min_idx}), 64'({POS_INF, 16'd0}));
        elems[0] = 32'h40E0_0000;
        do_search("after_rst", 1, 0, 0);

        for (int t = 0; t < 25; t++) begin
            int n = int'($urandom_range(0, 9));
            for (int i = 0; i < 16; i++) elems[i] = rand_float();
            do_search($sformatf("rnd%0d", t), n, int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
